// File: rtl/trace_player_pkg.sv
// ----------------------------------------------------------------------------
// trace_player_pkg
// Shared definitions for the access trace player:
//   - state_t          : player FSM encoding
//   - DEF_*            : default address width, trace length, counter width
//   - idx_width()      : index width for an n-entry table (never below 1 bit)
// ----------------------------------------------------------------------------
package trace_player_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int DEF_ADDR_WIDTH   = 11;
    localparam int DEF_TRACE_LENGTH = 10;
    localparam int DEF_CNT_WIDTH    = 8;

    // A single-entry table still needs a 1-bit index to be a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Statistics counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset, value -> 0
//   clear  in   synchronous clear to 0 (wins over inc)
//   inc    in   add one (saturating)
//   value  out  CNT_WIDTH current count
// ----------------------------------------------------------------------------
module sat_counter
    import trace_player_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] value
);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= sat_inc(value);
        end
    end

endmodule

// File: rtl/access_trace_player.sv
// ----------------------------------------------------------------------------
// access_trace_player
// Replays a stored list of addresses into three caches (direct, 2-way, 4-way)
// and counts hits per cache. Each entry is: one ISSUE cycle (read strobe),
// WAIT_CYCLES idle cycles, one SAMPLE cycle where hit flags are counted.
// A run ends with a one-cycle DONE; statistics hold until the next start.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   load_en/load_idx/load_addr  trace write port (accepted only when idle)
//   start                       run request (ignored while busy)
//   busy, done                  run in progress, one-cycle end-of-run pulse
//   cache_read, cache_addr      read strobe / address to all caches
//   hit_direct/2way/4way        hit flags from the caches
//   hits_direct/2way/4way       saturating hit counts
//   access_cnt                  saturating count of sampled accesses
//   loop_mode, stop             only with TRACE_PLAYER_LOOP_EN: wrap the
//                               trace endlessly; stop ends at next SAMPLE
//
// Optional feature macro: TRACE_PLAYER_LOOP_EN
// ----------------------------------------------------------------------------
module access_trace_player
    import trace_player_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int TRACE_LENGTH = DEF_TRACE_LENGTH,
    parameter int WAIT_CYCLES  = 1,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
`ifdef TRACE_PLAYER_LOOP_EN
    input  logic                                 loop_mode,
    input  logic                                 stop,
`endif
    input  logic                                 load_en,
    input  logic [idx_width(TRACE_LENGTH)-1:0]   load_idx,
    input  logic [ADDR_WIDTH-1:0]                load_addr,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 cache_read,
    output logic [ADDR_WIDTH-1:0]                cache_addr,
    input  logic                                 hit_direct,
    input  logic                                 hit_2way,
    input  logic                                 hit_4way,
    output logic [CNT_WIDTH-1:0]                 hits_direct,
    output logic [CNT_WIDTH-1:0]                 hits_2way,
    output logic [CNT_WIDTH-1:0]                 hits_4way,
    output logic [CNT_WIDTH-1:0]                 access_cnt
);

    localparam int IDX_W = idx_width(TRACE_LENGTH);
    localparam int WC_W  = idx_width(WAIT_CYCLES);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(TRACE_LENGTH - 1);
    localparam logic [WC_W-1:0]  WAIT_LAST   = WC_W'(WAIT_CYCLES - 1);
    localparam logic [IDX_W:0]   TRACE_LEN_X = (IDX_W + 1)'(TRACE_LENGTH);

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [WC_W-1:0]         wait_cnt, wait_nxt;
    logic                    cnt_clear;
    logic                    sample_en;
    logic [ADDR_WIDTH-1:0]   trace_mem [TRACE_LENGTH];

`ifdef TRACE_PLAYER_LOOP_EN
    logic                    stop_q, stop_nxt;
    logic                    stop_req;
`endif

    // Trace storage: data only, deliberately not reset so a trace survives
    // an aborted run. Writes are accepted only while idle.
    always_ff @(posedge clk) begin
        if (load_en && (state == S_IDLE) && ({1'b0, load_idx} < TRACE_LEN_X)) begin
            trace_mem[load_idx] <= load_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            wait_cnt <= '0;
`ifdef TRACE_PLAYER_LOOP_EN
            stop_q   <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            wait_cnt <= wait_nxt;
`ifdef TRACE_PLAYER_LOOP_EN
            stop_q   <= stop_nxt;
`endif
        end
    end

`ifdef TRACE_PLAYER_LOOP_EN
    // A stop seen in the SAMPLE cycle itself takes effect immediately.
    assign stop_req = stop_q | stop;
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        wait_nxt  = wait_cnt;
        cnt_clear = 1'b0;
`ifdef TRACE_PLAYER_LOOP_EN
        // Stop is remembered only while a run is active.
        stop_nxt  = (state != S_IDLE) && (state != S_DONE) && stop_req;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ISSUE;
                    idx_nxt   = '0;
                    cnt_clear = 1'b1;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
                wait_nxt  = '0;
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_SAMPLE;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            S_SAMPLE: begin
`ifdef TRACE_PLAYER_LOOP_EN
                if (stop_req) begin
                    state_nxt = S_DONE;
                end else if (idx != LAST_IDX) begin
                    state_nxt = S_ISSUE;
                    idx_nxt   = idx + 1'b1;
                end else if (loop_mode) begin
                    state_nxt = S_ISSUE;
                    idx_nxt   = '0;
                end else begin
                    state_nxt = S_DONE;
                end
`else
                if (idx != LAST_IDX) begin
                    state_nxt = S_ISSUE;
                    idx_nxt   = idx + 1'b1;
                end else begin
                    state_nxt = S_DONE;
                end
`endif
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state register so reset clears them
    // in the same cycle it is asserted.
    always_comb begin
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        cache_read = (state == S_ISSUE);
        sample_en  = (state == S_SAMPLE);
        cache_addr = '0;
        if ((state == S_ISSUE) || (state == S_WAIT) || (state == S_SAMPLE)) begin
            cache_addr = trace_mem[idx];
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_direct (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (sample_en & hit_direct),
        .value (hits_direct)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_2way (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (sample_en & hit_2way),
        .value (hits_2way)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_4way (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (sample_en & hit_4way),
        .value (hits_4way)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_access (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (sample_en),
        .value (access_cnt)
    );

endmodule

// File: tb/tb_access_trace_player.sv
// ----------------------------------------------------------------------------
// tb_access_trace_player
// Directed bench for access_trace_player: a default instance (10 entries,
// WAIT_CYCLES=1, 8-bit counters) and a small saturation instance (5 entries,
// WAIT_CYCLES=2, 2-bit counters, hit inputs tied high).
// Optional feature macro: TRACE_PLAYER_LOOP_EN (adds the loop scenario).
// ----------------------------------------------------------------------------
module tb_access_trace_player;

    localparam logic [10:0] TRACE_TAB [10] = '{
        11'h020, 11'h040, 11'h060, 11'h020, 11'h080,
        11'h0a0, 11'h040, 11'h0c0, 11'h0e0, 11'h020
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic [3:0]  load_idx;
    logic [10:0] load_addr;
    logic        start;
    logic        busy, done, cache_read;
    logic [10:0] cache_addr;
    logic        hit_direct, hit_2way, hit_4way;
    logic [7:0]  hits_direct, hits_2way, hits_4way, access_cnt;
`ifdef TRACE_PLAYER_LOOP_EN
    logic        loop_mode;
    logic        stop;
`endif

    logic        start2;
    logic        busy2, done2, cache_read2;
    logic [10:0] cache_addr2;
    logic [1:0]  hd2, h22, h42, acc2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    access_trace_player dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef TRACE_PLAYER_LOOP_EN
        .loop_mode   (loop_mode),
        .stop        (stop),
`endif
        .load_en     (load_en),
        .load_idx    (load_idx),
        .load_addr   (load_addr),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .cache_read  (cache_read),
        .cache_addr  (cache_addr),
        .hit_direct  (hit_direct),
        .hit_2way    (hit_2way),
        .hit_4way    (hit_4way),
        .hits_direct (hits_direct),
        .hits_2way   (hits_2way),
        .hits_4way   (hits_4way),
        .access_cnt  (access_cnt)
    );

    access_trace_player #(
        .ADDR_WIDTH   (11),
        .TRACE_LENGTH (5),
        .WAIT_CYCLES  (2),
        .CNT_WIDTH    (2)
    ) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef TRACE_PLAYER_LOOP_EN
        .loop_mode   (1'b0),
        .stop        (1'b0),
`endif
        .load_en     (1'b0),
        .load_idx    (3'd0),
        .load_addr   (11'h000),
        .start       (start2),
        .busy        (busy2),
        .done        (done2),
        .cache_read  (cache_read2),
        .cache_addr  (cache_addr2),
        .hit_direct  (1'b1),
        .hit_2way    (1'b1),
        .hit_4way    (1'b1),
        .hits_direct (hd2),
        .hits_2way   (h22),
        .hits_4way   (h42),
        .access_cnt  (acc2)
    );

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, cache_read} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctrl: busy/done/read got %b want 000", {busy, done, cache_read});
        end
        n_cmp++;
        if (cache_addr !== 11'h000) begin
            n_bad++;
            $display("FAIL reset_addr: got %h want 000", cache_addr);
        end
        n_cmp++;
        if ({hits_direct, hits_2way, hits_4way, access_cnt} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_cnt: got %h want 00000000",
                     {hits_direct, hits_2way, hits_4way, access_cnt});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic load_trace;
        for (int i = 0; i < 10; i++) begin
            load_en   = 1'b1;
            load_idx  = 4'(i);
            load_addr = TRACE_TAB[i];
            @(negedge clk);
        end
        load_en = 1'b0;
    endtask

    // Cycle k (1-based) after the start edge: entry (k-1)/3, phase
    // (k-1)%3 = ISSUE/WAIT/SAMPLE; cycle 31 is DONE.
    task automatic test_basic_run;
        int          e, ph;
        logic        exp_read;
        logic [10:0] exp_addr;
        logic [7:0]  exp_acc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            e        = (k - 1) / 3;
            ph       = (k - 1) % 3;
            exp_read = (k <= 30) && (ph == 0);
            exp_addr = 11'h000;
            if (k <= 30) exp_addr = TRACE_TAB[e];
            exp_acc  = 8'((k - 1) / 3);
            n_cmp++;
            if ({busy, done, cache_read} !== {1'b1, (k == 31), exp_read}) begin
                n_bad++;
                $display("FAIL run_ctrl cycle %0d: busy/done/read got %b want %b",
                         k, {busy, done, cache_read}, {1'b1, (k == 31), exp_read});
            end
            n_cmp++;
            if (cache_addr !== exp_addr) begin
                n_bad++;
                $display("FAIL run_addr cycle %0d: got %h want %h", k, cache_addr, exp_addr);
            end
            n_cmp++;
            if (access_cnt !== exp_acc) begin
                n_bad++;
                $display("FAIL run_access cycle %0d: got %0d want %0d", k, access_cnt, exp_acc);
            end
            // Hit flags are noise (all high) outside SAMPLE cycles.
            if ((k <= 30) && (ph == 2)) begin
                hit_direct = (e == 3) || (e == 9);
                hit_2way   = 1'b0;
                hit_4way   = (e == 0);
            end else begin
                hit_direct = 1'b1;
                hit_2way   = 1'b1;
                hit_4way   = 1'b1;
            end
            @(negedge clk);
        end
        for (int j = 0; j < 2; j++) begin
            n_cmp++;
            if ({busy, done, cache_read, cache_addr} !== 14'h0) begin
                n_bad++;
                $display("FAIL after_run_idle: busy/done/read/addr got %h want 0",
                         {busy, done, cache_read, cache_addr});
            end
            n_cmp++;
            if ({hits_direct, hits_2way, hits_4way, access_cnt} !== {8'd2, 8'd0, 8'd1, 8'd10}) begin
                n_bad++;
                $display("FAIL run_stats: got %0d/%0d/%0d/%0d want 2/0/1/10",
                         hits_direct, hits_2way, hits_4way, access_cnt);
            end
            @(negedge clk);
        end
        hit_direct = 1'b0;
        hit_2way   = 1'b0;
        hit_4way   = 1'b0;
    endtask

    task automatic test_start_load_during_run;
        int  done_cycle;
        logic seen_idle;
        done_cycle = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            if (done && (done_cycle == 0)) done_cycle = k;
            if (k == 32) begin
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL start_in_done: busy got %b want 0", busy);
                end
            end
            start     = (k == 5) || (k == 20) || (k == 31);
            load_en   = (k == 8);
            load_idx  = 4'd0;
            load_addr = 11'h7ff;
            @(negedge clk);
        end
        start   = 1'b0;
        load_en = 1'b0;
        n_cmp++;
        if (done_cycle != 31) begin
            n_bad++;
            $display("FAIL busy_start_done_cycle: got %0d want 31", done_cycle);
        end
        n_cmp++;
        if ({hits_direct, access_cnt} !== {8'd0, 8'd10}) begin
            n_bad++;
            $display("FAIL busy_start_stats: direct/access got %0d/%0d want 0/10",
                     hits_direct, access_cnt);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({cache_read, cache_addr} !== {1'b1, 11'h020}) begin
            n_bad++;
            $display("FAIL trace0_kept: read/addr got %b/%h want 1/020", cache_read, cache_addr);
        end
        seen_idle = 1'b0;
        for (int k = 0; k < 40 && !seen_idle; k++) begin
            @(negedge clk);
            seen_idle = !busy;
        end
        n_cmp++;
        if (!seen_idle) begin
            n_bad++;
            $display("FAIL rerun_finish: busy got 1 want 0 within 40 cycles");
        end
    endtask

    task automatic test_reset_mid_run;
        int done_seen;
        hit_direct = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);   // now in cycle 14: WAIT of entry 4
        n_cmp++;
        if ({cache_read, cache_addr, access_cnt, hits_direct} !== {1'b0, 11'h080, 8'd4, 8'd4}) begin
            n_bad++;
            $display("FAIL pre_reset: read/addr/access/direct got %b/%h/%0d/%0d want 0/080/4/4",
                     cache_read, cache_addr, access_cnt, hits_direct);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, cache_read, cache_addr} !== 14'h0) begin
            n_bad++;
            $display("FAIL async_reset_ctrl: busy/done/read/addr got %h want 0",
                     {busy, done, cache_read, cache_addr});
        end
        n_cmp++;
        if ({hits_direct, access_cnt} !== 16'h0) begin
            n_bad++;
            $display("FAIL async_reset_cnt: direct/access got %0d/%0d want 0/0",
                     hits_direct, access_cnt);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        hit_direct = 1'b0;
        done_seen  = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy) done_seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (done_seen != 0) begin
            n_bad++;
            $display("FAIL abandoned_run: busy/done cycles got %0d want 0", done_seen);
        end
    endtask

    task automatic test_saturation;
        int done_cycle;
        done_cycle = 0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (done2 && (done_cycle == 0)) done_cycle = k;
            if (k == 13) begin
                n_cmp++;
                if (acc2 !== 2'd3) begin
                    n_bad++;
                    $display("FAIL sat_reach: access got %0d want 3", acc2);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done_cycle != 21) begin
            n_bad++;
            $display("FAIL sat_done_cycle: got %0d want 21", done_cycle);
        end
        n_cmp++;
        if ({hd2, h22, h42, acc2} !== 8'hff) begin
            n_bad++;
            $display("FAIL sat_stick: got %0d/%0d/%0d/%0d want 3/3/3/3", hd2, h22, h42, acc2);
        end
        n_cmp++;
        if (busy2 !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_idle: busy got %b want 0", busy2);
        end
    endtask

`ifdef TRACE_PLAYER_LOOP_EN
    task automatic test_loop_stop;
        int done_cycle;
        done_cycle = 0;
        loop_mode  = 1'b1;
        hit_4way   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (done && (done_cycle == 0)) done_cycle = k;
            stop = (k == 37);         // ISSUE of entry 2, second pass
            @(negedge clk);
        end
        stop      = 1'b0;
        loop_mode = 1'b0;
        hit_4way  = 1'b0;
        n_cmp++;
        if (done_cycle != 40) begin
            n_bad++;
            $display("FAIL loop_done_cycle: got %0d want 40", done_cycle);
        end
        n_cmp++;
        if ({access_cnt, hits_4way} !== {8'd13, 8'd13}) begin
            n_bad++;
            $display("FAIL loop_stats: access/4way got %0d/%0d want 13/13", access_cnt, hits_4way);
        end
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        load_en    = 1'b0;
        load_idx   = 4'd0;
        load_addr  = 11'h000;
        start      = 1'b0;
        start2     = 1'b0;
        hit_direct = 1'b0;
        hit_2way   = 1'b0;
        hit_4way   = 1'b0;
`ifdef TRACE_PLAYER_LOOP_EN
        loop_mode  = 1'b0;
        stop       = 1'b0;
`endif
        test_reset();
        load_trace();
        test_basic_run();
        test_start_load_during_run();
        test_reset_mid_run();
        test_basic_run();
        test_saturation();
`ifdef TRACE_PLAYER_LOOP_EN
        test_loop_stop();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/access_trace_player.md
ACCESS_TRACE_PLAYER -- requirements
Module: access_trace_player

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, cache address width.
REQ-002 SHALL have parameter TRACE_LENGTH, default 10, trace entries per run (>=1).
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, idle cycles between read pulse and hit sample (>=1).
REQ-004 SHALL have parameter CNT_WIDTH, default 8, width of every statistics counter.
REQ-005 SHALL have ports: clk  in  1  clock, all logic on rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: load_en  in  1  trace write strobe; load_idx  in  clog2(TRACE_LENGTH)  entry index; load_addr  in  ADDR_WIDTH  entry address.
REQ-007 SHALL have ports: start  in  1  run request; busy  out  1  run in progress; done  out  1  one-cycle end-of-run pulse.
REQ-008 SHALL have ports: cache_read  out  1  read strobe to all caches; cache_addr  out  ADDR_WIDTH  address to all caches.
REQ-009 SHALL have ports: hit_direct, hit_2way, hit_4way  in  1 each  hit flags from direct, 2-way, 4-way caches.
REQ-010 SHALL have ports: hits_direct, hits_2way, hits_4way, access_cnt  out  CNT_WIDTH each  run statistics.

Function
REQ-011 SHALL store TRACE_LENGTH addresses in an internal array written when load_en=1 and state is IDLE; load_en in any other state SHALL be ignored.
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, SAMPLE, DONE.
REQ-013 IDLE -> ISSUE on start=1; counters and entry index SHALL clear to 0 on that edge.
REQ-014 ISSUE lasts exactly 1 cycle with cache_read=1 and cache_addr=trace[index]; -> WAIT.
REQ-015 WAIT lasts exactly WAIT_CYCLES cycles with cache_read=0, cache_addr held; -> SAMPLE.
REQ-016 SAMPLE lasts 1 cycle; each hits_* SHALL increment by 1 when its hit input is 1 at that edge; access_cnt SHALL increment by 1.
REQ-017 SAMPLE -> ISSUE with index+1 if index < TRACE_LENGTH-1, else -> DONE.
REQ-018 DONE lasts 1 cycle with done=1; -> IDLE; counters SHALL hold until next start.
REQ-019 busy SHALL be 1 in ISSUE, WAIT, SAMPLE, DONE and 0 in IDLE; start while busy=1 SHALL be ignored.
REQ-020 All counters SHALL saturate at 2^CNT_WIDTH-1, never wrap.
REQ-021 A run SHALL take exactly TRACE_LENGTH*(2+WAIT_CYCLES)+1 cycles from the start edge through DONE.
REQ-022 cache_addr SHALL be 0 in IDLE and DONE.

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, index 0, cache_read=0, cache_addr=0, busy=0, done=0, all counters 0, regardless of state.
REQ-024 Trace array contents SHALL NOT be reset; reset mid-run SHALL abandon the run with no done pulse.

Configuration
REQ-025 With macro TRACE_PLAYER_LOOP_EN defined, SHALL add input loop_mode (1 bit) and input stop (1 bit); SAMPLE of last entry with loop_mode=1 SHALL wrap index to 0 and go to ISSUE, counters continuing (saturating).
REQ-026 With TRACE_PLAYER_LOOP_EN defined, stop=1 SHALL be latched and take effect at the next SAMPLE, going to DONE.
REQ-027 Without TRACE_PLAYER_LOOP_EN, loop_mode and stop SHALL not exist and behaviour is REQ-017 only.

Structure
REQ-028 Package trace_player_pkg SHALL hold the FSM state typedef and default ADDR_WIDTH/TRACE_LENGTH/CNT_WIDTH constants.
REQ-029 Sub-module sat_counter (CNT_WIDTH, clear, inc, value) SHALL be instantiated four times for the statistics counters.

Verification
REQ-030 Load 020,040,060,020,080,0a0,040,0c0,0e0,020; start; hit_direct=1 on entries 3,9 only -> hits_direct=2, hits_2way=0, access_cnt=10, done pulse 31 cycles after start edge.
REQ-031 Monitor each entry -> cache_read high exactly 1 cycle with matching cache_addr, next read 3 cycles later (WAIT_CYCLES=1).
REQ-032 Pulse start and load_en(idx 0, 7ff) during run -> no restart, trace[0] unchanged, access_cnt=10 at done.
REQ-033 rst_n low during WAIT of entry 4 -> cache_read=0, busy=0, counters 0 same cycle; no done; restart replays original trace.
REQ-034 CNT_WIDTH=2, all hit inputs tied 1 -> hits_* and access_cnt stick at 3.
REQ-035 TRACE_PLAYER_LOOP_EN, loop_mode=1, stop asserted during entry 2 of second pass -> done after 13 SAMPLE cycles, access_cnt=13.
